// File: rtl/bcd_to_bin.sv
// Sequential 8-digit BCD to 27-bit binary converter (reverse double dabble, one bit per clock).
// Latency 27 cycles from accepting edge to done; invalid digits complete immediately with err.
module bcd_to_bin (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] number_bcd,
  output logic [31:0] number_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] bcd_reg, bcd_nxt;
  logic [26:0] bin_reg, bin_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [31:0] data_nxt;
  logic        busy_nxt, done_nxt, err_nxt;

  logic        bad_digit;
  logic [31:0] shifted;
  logic [31:0] corrected;
  logic [26:0] bin_shift;

  // Per-digit correction: a shifted nibble >= 8 has bit 3 set; nibbles never borrow.
  always_comb begin
    shifted   = bcd_reg >> 1;
    corrected = '0;
    for (int i = 0; i < 8; i++) begin
      corrected[4*i +: 4] = shifted[4*i +: 4] - (shifted[4*i+3] ? 4'd3 : 4'd0);
    end
    bin_shift = {bcd_reg[0], bin_reg[26:1]};
    bad_digit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (number_bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    bcd_nxt   = bcd_reg;
    bin_nxt   = bin_reg;
    cnt_nxt   = cnt;
    data_nxt  = number_data;
    busy_nxt  = busy;
    done_nxt  = done;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (start) begin
          if (bad_digit) begin
            data_nxt  = '0;
            err_nxt   = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            bcd_nxt   = number_bcd;
            bin_nxt   = '0;
            cnt_nxt   = 5'd26;
            err_nxt   = 1'b0;
            busy_nxt  = 1'b1;
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_nxt = corrected;
        bin_nxt = bin_shift;
        if (cnt != 5'd0) begin
          cnt_nxt = cnt - 5'd1;
        end else begin
          data_nxt  = {5'b0, bin_shift};
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bcd_reg     <= '0;
      bin_reg     <= '0;
      cnt         <= '0;
      number_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      bcd_reg     <= bcd_nxt;
      bin_reg     <= bin_nxt;
      cnt         <= cnt_nxt;
      number_data <= data_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Table-driven and randomized checks of bcd_to_bin against a decimal arithmetic reference.
module tb_bcd_to_bin;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] number_bcd;
  logic [31:0] number_data;
  logic        busy;
  logic        done;
  logic        err;

  int vectors;
  int miscompares;

  bcd_to_bin dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .number_bcd  (number_bcd),
    .number_data (number_data),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bcd;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: interpret each nibble as a decimal digit and accumulate.
  function automatic void ref_model(input logic [31:0] bcd, output logic [31:0] val, output logic bad);
    logic [3:0] d;
    val = 0;
    bad = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      d = bcd[4*i +: 4];
      if (d > 9) bad = 1'b1;
      val = val * 10 + 32'(d);
    end
    if (bad) val = 0;
  endfunction

  // Issue one start and watch 34 cycles; optional start poke and reset injection.
  task automatic do_conv(input logic [31:0] bcd, input int poke_at, input logic [31:0] poke_bcd,
                         input int rst_at, output logic [31:0] data, output logic e,
                         output int lat, output int busy_cnt, output int done_cnt,
                         output logic [31:0] bcd_end, output logic [31:0] data_end,
                         output logic rb, output logic [31:0] rdata);
    lat = -1; busy_cnt = 0; done_cnt = 0; data = '1; e = 1'bx; bcd_end = '1;
    rb = 1'b1; rdata = '1;
    @(negedge clk);
    start = 1'b1;
    number_bcd = bcd;
    @(posedge clk);
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = c; data = number_data; e = err; bcd_end = dut.bcd_reg;
        end
      end
      if (rst_at >= 0 && c == rst_at + 1) begin
        rb = busy; rdata = number_data; rst = 1'b0;
      end
      if (c == poke_at) begin start = 1'b1; number_bcd = poke_bcd; end
      if (poke_at >= 0 && c == poke_at + 1) start = 1'b0;
      if (c == rst_at) rst = 1'b1;
    end
    data_end = number_data;
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] bcd,
                               input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] data, bcd_end, data_end, rdata;
    logic e, rb;
    int lat, bc, dc;
    do_conv(bcd, -1, 0, -1, data, e, lat, bc, dc, bcd_end, data_end, rb, rdata);
    check({tag, " data"}, data, exp_data);
    check({tag, " err"}, 32'(e), 32'(exp_err));
    check({tag, " latency"}, 32'(lat), exp_err ? 32'd0 : 32'd27);
    check({tag, " busy_cycles"}, 32'(bc), exp_err ? 32'd0 : 32'd27);
    check({tag, " done_cycles"}, 32'(dc), 32'd1);
    check({tag, " hold"}, data_end, exp_data);
    if (!exp_err) check({tag, " bcd_reg_end"}, bcd_end, 32'd0);
  endtask

  initial begin
    vec_t vecs[8];
    logic [31:0] data, bcd_end, data_end, rdata, rbcd, rexp;
    logic e, rb, rbad;
    int lat, bc, dc;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start = 1'b0;
    number_bcd = '0;

    vecs[0] = '{32'h00000000, 32'h00000000, 1'b0};
    vecs[1] = '{32'h00001234, 32'h000004D2, 1'b0};
    vecs[2] = '{32'h12345678, 32'h00BC614E, 1'b0};
    vecs[3] = '{32'h99999999, 32'h05F5E0FF, 1'b0};
    vecs[4] = '{32'h0000001A, 32'h00000000, 1'b1};
    vecs[5] = '{32'h00000010, 32'h0000000A, 1'b0};
    vecs[6] = '{32'h00000042, 32'h0000002A, 1'b0};
    vecs[7] = '{32'hF0000000, 32'h00000000, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst number_data", number_data, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst bcd_reg", dut.bcd_reg, 32'd0);
    check("rst bin_reg", 32'(dut.bin_reg), 32'd0);
    check("rst cnt", 32'(dut.cnt), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].exp_data, vecs[i].exp_err);
    end

    // Start pulse during shift step 5 must be ignored.
    do_conv(32'h00000099, 4, 32'h00005555, -1, data, e, lat, bc, dc, bcd_end, data_end, rb, rdata);
    check("busyprot data", data, 32'h00000063);
    check("busyprot done_cycles", 32'(dc), 32'd1);
    check("busyprot latency", 32'(lat), 32'd27);

    // Reset sampled at shift step 10 discards the conversion.
    do_conv(32'h87654321, -1, 0, 9, data, e, lat, bc, dc, bcd_end, data_end, rb, rdata);
    check("midrst busy", 32'(rb), 32'd0);
    check("midrst number_data", rdata, 32'd0);
    check("midrst done_cycles", 32'(dc), 32'd0);
    run_and_check("after_midrst", 32'h00000042, 32'h0000002A, 1'b0);

    // rst and start on the same edge: start is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; number_bcd = 32'h00001234;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("simul busy", 32'(busy), 32'd0);
    bc = 0; dc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dc++;
    end
    check("simul busy_cycles", 32'(bc), 32'd0);
    check("simul done_cycles", 32'(dc), 32'd0);

    for (int n = 0; n < 16; n++) begin
      rbcd = '0;
      for (int d = 0; d < 8; d++) rbcd[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) rbcd[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
      ref_model(rbcd, rexp, rbad);
      run_and_check($sformatf("rand%0d_%08h", n, rbcd), rbcd, rexp, rbad);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential BCD-to-binary converter, the decode counterpart of the team's shift-and-add-3 binary-to-BCD encoder. It accepts an 8-digit packed BCD value and produces its binary equivalent using reverse double dabble: shift right, then subtract 3 from each digit that is ≥ 8, one bit per clock. It sits between keypad/display-side BCD registers and the arithmetic datapath. A start/busy/done handshake frames each conversion, and non-BCD input is flagged with an error.

## Interface
- No parameters. Widths are fixed: 8 digits in, 27 significant result bits, 32-bit output.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  conversion request; sampled only in IDLE.
- number_bcd  in  32  packed BCD input; digit 0 is [3:0], digit 7 is [31:28]; sampled on the accepting edge only.
- number_data  out  32  binary result; bits [31:27] are always 0; holds its value until the next completion.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle completion pulse.
- err  out  1  high when the last request contained a nibble > 9; holds until the next accepted start.

## Operation
- Internal registers:
  - bcd_reg[31:0]: working BCD value.
  - bin_reg[26:0]: binary accumulator.
  - cnt[4:0]: shift counter.
  - state: 2-bit FSM.
- **IDLE**, when start=1:
  - If any nibble of number_bcd is > 9: number_data<=0, err<=1, done<=1, go to DONE. No shifting occurs.
  - Otherwise: bcd_reg<=number_bcd, bin_reg<=0, cnt<=26, err<=0, busy<=1, go to SHIFT.
  - start=0: stay in IDLE.
- **SHIFT**, one step per clock:
  - Shift right: bin_next = {bcd_reg[0], bin_reg[26:1]}; t = bcd_reg>>1.
  - For each of the 8 nibbles of t: if the nibble is ≥ 8, subtract 3. All nibbles are corrected in parallel in the same cycle; a nibble never borrows from its neighbour.
  - bcd_reg<=corrected t, bin_reg<=bin_next.
  - When cnt≠0: cnt<=cnt-1.
  - When cnt==0: number_data<={5'b0, bin_next}, done<=1, busy<=0, go to DONE.
- **DONE**: done<=0, go to IDLE. start is ignored in this state.
- start is ignored while in SHIFT or DONE; there is no queueing.
- For valid input, bcd_reg is 0 after the final step. The bench checks this through a hierarchical probe.
- **Reset** (any state, including mid-conversion):
  - state=IDLE, number_data=0, busy=0, done=0, err=0, bcd_reg=0, bin_reg=0, cnt=0.
  - An in-flight conversion is discarded and no done is produced.

## Timing
- Start accepted at edge k:
  - busy is 1 from after edge k until after edge k+27.
  - Shift steps occur at edges k+1..k+27 (27 steps).
  - number_data is valid and done=1 from edge k+27; done falls at edge k+28.
- Valid-input latency from the accepting edge to done is 27 cycles.
- Minimum start-to-start spacing is 29 cycles (next start accepted at edge k+29 at the earliest).
- Invalid input: err=1, number_data=0 and done=1 from edge k; done falls at edge k+1. The next start can be accepted at edge k+2.
- rst and start high in the same cycle: rst wins and start is dropped.
- Maximum input 99,999,999 < 2^27, so the result never overflows 27 bits.

## Test plan
- Reset check: assert rst for 2 cycles → number_data=0, busy=0, done=0, err=0, state IDLE.
- Value checks, each issued as start with the given number_bcd:
  - 0x00000000 → done at edge +27, number_data=0x00000000, err=0.
  - 0x00001234 → 0x000004D2.
  - 0x12345678 → 0x00BC614E.
  - 0x99999999 → 0x05F5E0FF.
  - In every case, done is high exactly 1 cycle and busy is high exactly 27 cycles.
- Invalid digit: number_bcd=0x0000001A → done at edge +0 with err=1 and number_data=0. The following valid start with 0x00000010 → number_data=0x0000000A and err clears to 0.
- Busy protection: start 0x00000099, then pulse start with 0x00005555 during shift step 5 → result is 0x00000063 and exactly one done pulse is produced.
- Mid-operation reset: start 0x87654321, assert rst at shift step 10 → next cycle busy=0, number_data=0, and no done. Then start 0x00000042 → number_data=0x0000002A after 27 cycles.
- Simultaneous events: rst=1 and start=1 on the same edge → stays in IDLE, busy stays 0, and no done is produced.
